// File: rtl/accumulator_ctrl_if.sv
// -----------------------------------------------------------------------------
// accumulator_ctrl_if
// Stream bundle between the systolic array, the accumulator controller and the
// unified-buffer writer.
//   in_valid / in_ready / in_data        : column results from the array
//   out_valid / out_ready / out_data /
//   out_idx                              : drain words to the buffer writer
// Modports:
//   slave  : accumulator side (accepts columns, produces drain words)
//   master : environment side (array + buffer writer)
// -----------------------------------------------------------------------------
interface accumulator_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ROWS   = 2
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx
    );
endinterface

// File: rtl/accumulator_ctrl.sv
// -----------------------------------------------------------------------------
// accumulator_ctrl
// Sequencing controller and ROWS-entry storage bank for the accumulator stage.
// Collects num_tiles K-tiles of column results (tile 0 overwrites the bank,
// later tiles are summed in), then drains the bank over a valid/ready stream.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : job request, honoured only when idle
//   num_tiles  : tile count, sampled when start is accepted
//   bus        : accumulator_ctrl_if.slave (column input + drain output)
//   busy       : job in progress (FILL or DRAIN)
//   done       : one-cycle pulse at job end
//   sat        : sticky saturation flag for the current job
//
// Build option:
//   ACC_CTRL_SATURATE_EN : when defined, tile sums clamp to the signed DATA_W
//                          limits and set sat; otherwise sums wrap, sat = 0.
// -----------------------------------------------------------------------------
module accumulator_ctrl #(
    parameter int ROWS   = 2,
    parameter int DATA_W = 32,
    parameter int TILE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TILE_W-1:0]        num_tiles,
    accumulator_ctrl_if.slave        bus,
    output logic                     busy,
    output logic                     done,
    output logic                     sat
);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [DATA_W-1:0] mem_r [ROWS];
    logic [IDX_W-1:0]  row_idx_r;
    logic [IDX_W-1:0]  drain_idx_r;
    logic [TILE_W-1:0] tile_cnt_r;
    logic [TILE_W-1:0] num_tiles_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              beat_s;
    logic              last_beat_s;
    logic              xfer_s;
    logic              drain_last_s;
    logic [DATA_W-1:0] acc_val_s;

`ifdef ACC_CTRL_SATURATE_EN
    logic              sat_r;
    logic              sat_hit_s;

    // Signed add clamped to the DATA_W limits; MSB of the result flags a clamp.
    function automatic logic [DATA_W:0] add_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] s;
        logic              ovf;
        s   = a + b;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
        if (!ovf) begin
            return {1'b0, s};
        end else if (a[DATA_W-1]) begin
            return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

    assign sat = sat_r;
`else
    assign sat = 1'b0;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    // Drain word is read straight from the bank so it holds under backpressure.
    assign bus.out_data  = out_valid_r ? mem_r[drain_idx_r] : {DATA_W{1'b0}};
    assign bus.out_idx   = out_valid_r ? drain_idx_r : {IDX_W{1'b0}};
    assign busy          = busy_r;
    assign done          = done_r;

    // Handshake decode and the value written back into the bank this beat.
    always_comb begin
        beat_s       = bus.in_valid && in_ready_r;
        last_beat_s  = (row_idx_r == IDX_W'(ROWS - 1)) &&
                       (tile_cnt_r == (num_tiles_r - TILE_W'(1)));
        xfer_s       = out_valid_r && bus.out_ready;
        drain_last_s = (drain_idx_r == IDX_W'(ROWS - 1));
`ifdef ACC_CTRL_SATURATE_EN
        sat_hit_s    = 1'b0;
        if (tile_cnt_r == {TILE_W{1'b0}}) begin
            acc_val_s = bus.in_data;
        end else begin
            {sat_hit_s, acc_val_s} = add_sat(mem_r[row_idx_r], bus.in_data);
        end
`else
        if (tile_cnt_r == {TILE_W{1'b0}}) begin
            acc_val_s = bus.in_data;
        end else begin
            acc_val_s = mem_r[row_idx_r] + bus.in_data;
        end
`endif
    end

    // Next-state logic for the job sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_tiles == {TILE_W{1'b0}}) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (beat_s && last_beat_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && drain_last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_FILL);
            out_valid_r <= (state_nxt_s == ST_DRAIN);
            busy_r      <= (state_nxt_s == ST_FILL) || (state_nxt_s == ST_DRAIN);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    // Bank, counters and job parameters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROWS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            row_idx_r   <= {IDX_W{1'b0}};
            drain_idx_r <= {IDX_W{1'b0}};
            tile_cnt_r  <= {TILE_W{1'b0}};
            num_tiles_r <= {TILE_W{1'b0}};
`ifdef ACC_CTRL_SATURATE_EN
            sat_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        num_tiles_r <= num_tiles;
                        row_idx_r   <= {IDX_W{1'b0}};
                        tile_cnt_r  <= {TILE_W{1'b0}};
`ifdef ACC_CTRL_SATURATE_EN
                        sat_r       <= 1'b0;
`endif
                    end
                end
                ST_FILL: begin
                    if (beat_s) begin
                        mem_r[row_idx_r] <= acc_val_s;
`ifdef ACC_CTRL_SATURATE_EN
                        sat_r <= sat_r | sat_hit_s;
`endif
                        if (row_idx_r == IDX_W'(ROWS - 1)) begin
                            row_idx_r  <= {IDX_W{1'b0}};
                            tile_cnt_r <= tile_cnt_r + TILE_W'(1);
                        end else begin
                            row_idx_r  <= row_idx_r + IDX_W'(1);
                        end
                        if (last_beat_s) begin
                            drain_idx_r <= {IDX_W{1'b0}};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer_s) begin
                        if (drain_last_s) begin
                            drain_idx_r <= {IDX_W{1'b0}};
                        end else begin
                            drain_idx_r <= drain_idx_r + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequencing controller and storage bank for the TPU accumulator stage. It collects column results from the systolic array over one or more K-tiles, summing successive tiles into a ROWS-entry bank. After the last tile it drains the bank to the unified-buffer writer over a valid/ready handshake. Software starts one job at a time and sees `busy` and a one-cycle `done`.

## Interface
- `ROWS`, 2: bank entries per tile; ≥2.
- `DATA_W`, 32: datapath width.
- `TILE_W`, 8: width of the tile count.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset); released synchronously by the system.
- `start`  in  1  job request; honoured only in IDLE.
- `num_tiles`  in  TILE_W  K-tiles to accumulate; sampled when `start` is accepted.
- `in_valid`  in  1  array column result valid.
- `in_data`  in  DATA_W  signed column result.
- `in_ready`  out  1  high only in FILL.
- `out_valid`  out  1  drain word valid.
- `out_data`  out  DATA_W  drain word.
- `out_idx`  out  max(1,$clog2(ROWS))  bank index of `out_data`.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high in FILL and DRAIN.
- `done`  out  1  one-cycle pulse at job end.
- `sat`  out  1  sticky per job; see Configuration.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE + `start`=1:
  - latch `num_tiles`; clear `row_idx`, `tile_cnt` and `sat`.
  - next state FILL, or DONE if `num_tiles`=0.
- `start` outside IDLE is ignored and never queued.
- FILL, on each accepted beat (`in_valid` && `in_ready`):
  - tile 0: `mem[row_idx]` <= `in_data` (overwrite; stale contents never summed).
  - later tiles: `mem[row_idx]` <= `mem[row_idx]` + `in_data`, signed, DATA_W result.
  - `row_idx` increments; at ROWS-1 it wraps to 0 and `tile_cnt` increments.
  - a zero-valued `in_data` is a valid beat and is counted.
- The beat with `row_idx`=ROWS-1 and `tile_cnt`=num_tiles-1 moves to DRAIN; `drain_idx` <= 0.
- DRAIN:
  - `out_valid`=1; `out_data`=`mem[drain_idx]` and `out_idx`=`drain_idx`, both combinational from registered state.
  - `out_data` and `out_idx` hold while `out_ready`=0.
  - on a transfer `drain_idx` increments; the transfer at ROWS-1 moves to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Bank contents persist after the job until the next tile-0 overwrite.
- `in_valid` outside FILL is dropped; `in_ready`=0 there.

## Timing
- Reset values:
  - state IDLE; `row_idx`, `tile_cnt`, `drain_idx` = 0; all `mem` = 0.
  - `in_ready`, `out_valid`, `busy`, `done`, `sat` = 0; `out_data` = 0; `out_idx` = 0.
- Reset asserted mid-job aborts immediately to the reset values above; no `done`.
- `start` at edge N: `busy`=1 and `in_ready`=1 from cycle N+1.
- FILL accepts one beat per cycle; no bubbles.
- Last FILL beat at edge M: `out_valid`=1 from cycle M+1.
- Drain with `out_ready` held high: ROWS cycles.
- Last transfer at edge P: `done`=1 in cycle P+1 and `busy`=0 in P+1. `start` is accepted again from cycle P+2.
- Minimum job length: 1 + num_tiles·ROWS + ROWS + 1 cycles.
- `num_tiles`=0: `done` pulses in the cycle after `start`; no FILL, no DRAIN, bank untouched.

## Configuration
- `ACC_CTRL_SATURATE_EN`
  - Defined: tile sums saturate to signed DATA_W limits (32-bit: 0x7FFFFFFF / 0x80000000). Any saturation sets `sat`, which stays set until the next accepted `start` or reset.
  - Undefined: sums wrap modulo 2^DATA_W; `sat` tied to 0.
  - Tile 0 overwrites never saturate.

## Test plan
- Reset then `start`, `num_tiles`=1, inputs 5, 7, `out_ready`=1:
  - drain idx0=5, idx1=7; `done` 1 cycle after the second transfer; `busy` low in the `done` cycle.
- `num_tiles`=3, beats (1,2),(10,20),(100,200):
  - drain 111, 222.
  - a second job of 1 tile with (4,0) drains 4, 0 with no carry-over; the 0 beat is counted.
- Drain backpressure: `out_ready`=0 for 3 cycles at idx0:
  - `out_data` and `out_idx` stable for those 3 cycles.
  - `in_valid` pulses during DRAIN are ignored; bank unchanged.
- `num_tiles`=0:
  - `done` the cycle after `start`; `out_valid` never asserts.
  - `start` during FILL does not restart the job.
- Reset pulled low mid-FILL after 1 beat:
  - all outputs return to reset values with no `done`.
  - a fresh 1-tile job (9,9) drains 9, 9.
- 2 tiles: beats (0x7FFFFFFF,−1) then (1,−0x80000000):
  - macro defined: drain 0x7FFFFFFF, 0x80000000; `sat`=1.
  - macro undefined: drain 0x80000000, 0x7FFFFFFF; `sat`=0.
